// File: rtl/bin_to_bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the internal digit-count calculation.
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_NINE = 4'h9;

    // log10(2) ~= 0.301, so this gives enough digits to hold 2^width - 1.
    function automatic int bcd_digits_needed(input int width);
        return (width * 301) / 1000 + 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: add 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    always_comb begin
        d_o = d_i;
        if (d_i >= 4'd5) begin
            d_o = d_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
// Define BIN_TO_BCD_BLANK_EN to add the registered leading-zero mask o_blank.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; published outputs hold the last result
// SHIFT | one adjust-and-shift per cycle, WIDTH cycles in total
// LOAD  | saturate/overflow check, publish result, pulse done
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    i_bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] o_bcd,
    output logic                o_ovf
`ifdef BIN_TO_BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]   o_blank
`endif
);

    localparam int IDIGITS = bcd_digits_needed(WIDTH);
    localparam int SW      = 4 * IDIGITS;
    localparam int BW      = 4 * DIGITS;
    localparam int CW      = $clog2(WIDTH + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [SW-1:0]  scratch_q, scratch_d, scratch_adj;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           ovf_q, ovf_d;
    logic [BW-1:0]  bcd_q, bcd_d;
    logic [BW-1:0]  low_digits;
    logic           hi_nz;

    for (genvar g = 0; g < IDIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (scratch_q[4*g +: 4]),
            .d_o (scratch_adj[4*g +: 4])
        );
    end

    if (DIGITS < IDIGITS) begin : g_trunc
        assign low_digits = scratch_q[BW-1:0];
        assign hi_nz      = |scratch_q[SW-1:BW];
    end else begin : g_ext
        assign low_digits = BW'(scratch_q);
        assign hi_nz      = 1'b0;
    end

`ifdef BIN_TO_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_calc;
    logic              zero_above;

    always_comb begin
        blank_calc = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above    = zero_above & (low_digits[4*k +: 4] == 4'd0);
            blank_calc[k] = zero_above;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
`ifdef BIN_TO_BCD_BLANK_EN
        blank_d   = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = i_bin;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Rotate rather than shift: the scratch MSB is provably 0
                // because IDIGITS covers 2^WIDTH-1, so this equals a shift.
                {scratch_d, shreg_d} = {scratch_adj[SW-2:0], shreg_q, scratch_adj[SW-1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ovf_d   = hi_nz;
                bcd_d   = hi_nz ? {DIGITS{BCD_NINE}} : low_digits;
`ifdef BIN_TO_BCD_BLANK_EN
                blank_d = hi_nz ? '0 : blank_calc;
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            scratch_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
`ifdef BIN_TO_BCD_BLANK_EN
            blank_q   <= ~DIGITS'(1);
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
`ifdef BIN_TO_BCD_BLANK_EN
            blank_q   <= blank_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign o_bcd   = bcd_q;
    assign o_ovf   = ovf_q;
`ifdef BIN_TO_BCD_BLANK_EN
    assign o_blank = blank_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 16-bit/4-digit instance and an
// 8-bit/2-digit instance driven with hand-computed vectors.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] i_bin;
    logic        busy, done, o_ovf;
    logic [15:0] o_bcd;
    logic        start8;
    logic [7:0]  bin8;
    logic        busy8, done8, ovf8;
    logic [7:0]  bcd8;
`ifdef BIN_TO_BCD_BLANK_EN
    logic [3:0]  o_blank;
    logic [1:0]  blank8;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .i_bin   (i_bin),
        .busy    (busy),
        .done    (done),
        .o_bcd   (o_bcd),
        .o_ovf   (o_ovf)
`ifdef BIN_TO_BCD_BLANK_EN
        ,
        .o_blank (o_blank)
`endif
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .i_bin   (bin8),
        .busy    (busy8),
        .done    (done8),
        .o_bcd   (bcd8),
        .o_ovf   (ovf8)
`ifdef BIN_TO_BCD_BLANK_EN
        ,
        .o_blank (blank8)
`endif
    );

    localparam logic [15:0] SAT_IN   [6] = '{16'd9999, 16'd10000, 16'd65535, 16'd0, 16'd47, 16'd305};
    localparam logic [15:0] SAT_BCD  [6] = '{16'h9999, 16'h9999, 16'h9999, 16'h0000, 16'h0047, 16'h0305};
    localparam logic        SAT_OVF  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [3:0]  SAT_BLNK [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b1110, 4'b1100, 4'b1000};

    localparam logic [7:0]  NAR_IN   [5] = '{8'd255, 8'd99, 8'd100, 8'd42, 8'd0};
    localparam logic [7:0]  NAR_BCD  [5] = '{8'h99, 8'h99, 8'h99, 8'h42, 8'h00};
    localparam logic        NAR_OVF  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [1:0]  NAR_BLNK [5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10};

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_start(input logic [15:0] v);
        start = 1'b1;
        i_bin = v;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen (-1 on timeout) and busy samples before it.
    task automatic wait_done(output int cyc, output int busy_cyc);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        cyc = -1;
        busy_cyc = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                seen = 1'b1;
                cyc = n;
            end else if (busy) begin
                busy_cyc++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        i_bin  = '0;
        start8 = 1'b0;
        bin8   = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++; if (o_bcd !== 16'h0)   begin bad++; $display("FAIL reset_bcd got=%h want=0000", o_bcd); end
        total++; if (o_ovf !== 1'b0)    begin bad++; $display("FAIL reset_ovf got=%0b want=0", o_ovf); end
        total++; if (busy8 !== 1'b0)    begin bad++; $display("FAIL reset_busy8 got=%0b want=0", busy8); end
`ifdef BIN_TO_BCD_BLANK_EN
        total++; if (o_blank !== 4'b1110) begin bad++; $display("FAIL reset_blank got=%b want=1110", o_blank); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc, bc;
        do_start(16'd1234);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_after_start got=%0b want=1", busy); end
        wait_done(cyc, bc);
        total++; if (cyc != 17)        begin bad++; $display("FAIL basic_latency got=%0d want=17", cyc); end
        total++; if (bc + 1 != 17)     begin bad++; $display("FAIL basic_busy_cycles got=%0d want=17", bc + 1); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL basic_busy_at_done got=%0b want=0", busy); end
        total++; if (o_bcd !== 16'h1234) begin bad++; $display("FAIL basic_bcd got=%h want=1234", o_bcd); end
        total++; if (o_ovf !== 1'b0)   begin bad++; $display("FAIL basic_ovf got=%0b want=0", o_ovf); end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL basic_done_width got=%0b want=0", done); end
        total++; if (o_bcd !== 16'h1234) begin bad++; $display("FAIL basic_bcd_hold got=%h want=1234", o_bcd); end
    endtask

    task automatic test_saturate();
        int cyc, bc;
        for (int i = 0; i < 6; i++) begin
            do_start(SAT_IN[i]);
            wait_done(cyc, bc);
            total++; if (cyc != 17) begin bad++; $display("FAIL sat_latency in=%0d got=%0d want=17", SAT_IN[i], cyc); end
            total++; if (o_bcd !== SAT_BCD[i]) begin bad++; $display("FAIL sat_bcd in=%0d got=%h want=%h", SAT_IN[i], o_bcd, SAT_BCD[i]); end
            total++; if (o_ovf !== SAT_OVF[i]) begin bad++; $display("FAIL sat_ovf in=%0d got=%0b want=%0b", SAT_IN[i], o_ovf, SAT_OVF[i]); end
`ifdef BIN_TO_BCD_BLANK_EN
            total++; if (o_blank !== SAT_BLNK[i]) begin bad++; $display("FAIL sat_blank in=%0d got=%b want=%b", SAT_IN[i], o_blank, SAT_BLNK[i]); end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        do_start(16'd500);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        i_bin = 16'd321;
        @(posedge clk);
        #1;
        start = 1'b0;
        i_bin = 16'd9876;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_mid got=%0b want=1", busy); end
        wait_done(cyc, bc);
        total++; if (cyc + 5 != 17)     begin bad++; $display("FAIL b2b_ignore_latency got=%0d want=17", cyc + 5); end
        total++; if (o_bcd !== 16'h0500) begin bad++; $display("FAIL b2b_ignore_bcd got=%h want=0500", o_bcd); end
        do_start(16'd321);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy got=%0b want=1", busy); end
        total++; if (o_bcd !== 16'h0500) begin bad++; $display("FAIL b2b_hold_bcd got=%h want=0500", o_bcd); end
        wait_done(cyc, bc);
        total++; if (cyc != 17)          begin bad++; $display("FAIL b2b_latency got=%0d want=17", cyc); end
        total++; if (o_bcd !== 16'h0321) begin bad++; $display("FAIL b2b_bcd got=%h want=0321", o_bcd); end
    endtask

    task automatic test_reset_abort();
        int cyc, bc;
        do_start(16'd4321);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
        total++; if (o_bcd !== 16'h0)  begin bad++; $display("FAIL abort_bcd got=%h want=0000", o_bcd); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL abort_done got=%0b want=0", done); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL abort_idle_after got=%0b want=0", busy); end
        do_start(16'd4321);
        wait_done(cyc, bc);
        total++; if (cyc != 17)          begin bad++; $display("FAIL abort_rerun_latency got=%0d want=17", cyc); end
        total++; if (o_bcd !== 16'h4321) begin bad++; $display("FAIL abort_rerun_bcd got=%h want=4321", o_bcd); end
    endtask

    task automatic test_narrow();
        int n;
        int cyc;
        for (int i = 0; i < 5; i++) begin
            start8 = 1'b1;
            bin8   = NAR_IN[i];
            @(posedge clk);
            #1;
            start8 = 1'b0;
            n = 0;
            cyc = -1;
            while (cyc < 0 && n < 50) begin
                @(posedge clk);
                #1;
                n++;
                if (done8) cyc = n;
            end
            total++; if (cyc != 9) begin bad++; $display("FAIL narrow_latency in=%0d got=%0d want=9", NAR_IN[i], cyc); end
            total++; if (bcd8 !== NAR_BCD[i]) begin bad++; $display("FAIL narrow_bcd in=%0d got=%h want=%h", NAR_IN[i], bcd8, NAR_BCD[i]); end
            total++; if (ovf8 !== NAR_OVF[i]) begin bad++; $display("FAIL narrow_ovf in=%0d got=%0b want=%0b", NAR_IN[i], ovf8, NAR_OVF[i]); end
`ifdef BIN_TO_BCD_BLANK_EN
            total++; if (blank8 !== NAR_BLNK[i]) begin bad++; $display("FAIL narrow_blank in=%0d got=%b want=%b", NAR_IN[i], blank8, NAR_BLNK[i]); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_back_to_back();
        test_reset_abort();
        test_narrow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
